// File: rtl/acc_flags.sv
// -----------------------------------------------------------------------------
// acc_flags -- SAP-2 accumulator (A) plus Z/S condition flags.
//
// A feeds the ALU's `a` input. It is loaded from the system bus, written back
// from the ALU result, or incremented/decremented in place. Z/S track the last
// arithmetic result and drive the conditional-jump decision.
//
// Optional build macro: FLAG_PARITY_EN
//   Adds the flag_p output, which holds the even parity of the last result.
//   It also widens cond_sel to 3 bits so that PE/PO conditions are available.
//
// Ports:
//   clk        system clock, rising-edge
//   rst        asynchronous active-high reset
//   bus        16-bit system bus; bus[WIDTH-1:0] is captured on load
//   alu_out    ALU result, captured on wr_alu
//   load       A <= bus[WIDTH-1:0], flags hold
//   wr_alu     A <= alu_out, flags updated
//   inc / dec  A <= A +/- 1 (wrapping), flags updated
//   en         drive A onto bus_out (OR-muxed bus, zero when idle)
//   cond_sel   0=Z 1=NZ 2=M 3=P [4=PE 5=PO 6/7=never, with FLAG_PARITY_EN]
//   a          registered accumulator
//   bus_out    {zero-extend, A} when en, else all zeros
//   flag_z     zero flag
//   flag_s     sign flag
//   flag_p     even-parity flag (FLAG_PARITY_EN only)
//   cond_true  selected condition evaluated on the registered flags
// -----------------------------------------------------------------------------
module acc_flags #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      bus,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             load,
    input  logic             wr_alu,
    input  logic             inc,
    input  logic             dec,
    input  logic             en,
`ifdef FLAG_PARITY_EN
    input  logic [2:0]       cond_sel,
`else
    input  logic [1:0]       cond_sel,
`endif
    output logic [WIDTH-1:0] a,
    output logic [15:0]      bus_out,
    output logic             flag_z,
    output logic             flag_s,
`ifdef FLAG_PARITY_EN
    output logic             flag_p,
`endif
    output logic             cond_true
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] a_next;
    logic             flag_z_reg;
    logic             flag_z_next;
    logic             flag_s_reg;
    logic             flag_s_next;
    logic             upd_flags;

    // ------------------------------------------------------------------
    // Next-state selection. The strobes are prioritised so that at most
    // one operation takes effect: load > wr_alu > inc > dec.
    // ------------------------------------------------------------------
    always_comb begin
        a_next    = a_reg;
        upd_flags = 1'b0;
        if (load) begin
            a_next = bus[WIDTH-1:0];
        end else if (wr_alu) begin
            a_next    = alu_out;
            upd_flags = 1'b1;
        end else if (inc) begin
            a_next    = a_reg + ONE;
            upd_flags = 1'b1;
        end else if (dec) begin
            a_next    = a_reg - ONE;
            upd_flags = 1'b1;
        end
    end

    // Flags are derived from the value that A is about to take, not from the
    // current A. This keeps them coherent with A after the edge.
    always_comb begin
        flag_z_next = flag_z_reg;
        flag_s_next = flag_s_reg;
        if (upd_flags) begin
            flag_z_next = (a_next == '0);
            flag_s_next = a_next[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            flag_z_reg <= 1'b0;
            flag_s_reg <= 1'b0;
        end else begin
            a_reg      <= a_next;
            flag_z_reg <= flag_z_next;
            flag_s_reg <= flag_s_next;
        end
    end

`ifdef FLAG_PARITY_EN
    logic flag_p_reg;
    logic flag_p_next;

    // Reduction XNOR is 1 when the number of set bits is even.
    always_comb begin
        flag_p_next = flag_p_reg;
        if (upd_flags) begin
            flag_p_next = ~^a_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_p_reg <= 1'b0;
        end else begin
            flag_p_reg <= flag_p_next;
        end
    end

    assign flag_p = flag_p_reg;
`endif

    // ------------------------------------------------------------------
    // Condition decode. It uses only the registered flags, so a jump
    // decision never sees a flag that is still being computed this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        cond_true = 1'b0;
        case (cond_sel)
            'd0:     cond_true = flag_z_reg;
            'd1:     cond_true = ~flag_z_reg;
            'd2:     cond_true = flag_s_reg;
            'd3:     cond_true = ~flag_s_reg;
`ifdef FLAG_PARITY_EN
            'd4:     cond_true = flag_p_reg;
            'd5:     cond_true = ~flag_p_reg;
`endif
            default: cond_true = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus driver. The bus is OR-muxed, so an idle driver presents zeros.
    // Bits above WIDTH are always zero. The driver uses registered A, so
    // en together with load shows the old value during that cycle.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bus_out
            if (gi < WIDTH) begin : g_data
                assign bus_out[gi] = en & a_reg[gi];
            end else begin : g_zero
                assign bus_out[gi] = 1'b0;
            end
        end

        // The upper bus bits belong to other consumers. They are folded
        // here only so that the port is fully referenced.
        if (WIDTH < 16) begin : g_bus_hi
            logic bus_hi_unused;
            assign bus_hi_unused = ^bus[15:WIDTH];
        end
    endgenerate

    assign a      = a_reg;
    assign flag_z = flag_z_reg;
    assign flag_s = flag_s_reg;

endmodule

// File: tb/tb_acc_flags.sv
// -----------------------------------------------------------------------------
// tb_acc_flags -- scoreboard bench for acc_flags.
// A driver applies one transaction per clock on the falling edge. It pushes
// the response predicted by an arithmetic reference model into a queue. A
// monitor pops that queue 1 ns after every rising edge and compares the
// response with the DUT outputs. The bench runs directed cases first, then a
// randomised phase.
// -----------------------------------------------------------------------------
module tb_acc_flags;

`ifdef FLAG_PARITY_EN
    localparam int CSW = 3;
`else
    localparam int CSW = 2;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [15:0]    bus;
    logic [7:0]     alu_out;
    logic           load, wr_alu, inc, dec, en;
    logic [CSW-1:0] cond_sel;
    logic [7:0]     a;
    logic [15:0]    bus_out;
    logic           flag_z, flag_s, cond_true;
`ifdef FLAG_PARITY_EN
    logic           flag_p;
`endif

    acc_flags #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_out  (alu_out),
        .load     (load),
        .wr_alu   (wr_alu),
        .inc      (inc),
        .dec      (dec),
        .en       (en),
        .cond_sel (cond_sel),
        .a        (a),
        .bus_out  (bus_out),
        .flag_z   (flag_z),
        .flag_s   (flag_s),
`ifdef FLAG_PARITY_EN
        .flag_p   (flag_p),
`endif
        .cond_true(cond_true)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    a;
        bit    z;
        bit    s;
        bit    p;
        bit    ct;
        int    bo;
        string tag;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state.
    int m_a = 0;
    bit m_z = 0, m_s = 0, m_p = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic bit cond_of(input int sel, input bit z, input bit s, input bit p);
        case (sel)
            0: return z;
            1: return !z;
            2: return s;
            3: return !s;
`ifdef FLAG_PARITY_EN
            4: return p;
            5: return !p;
`endif
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock edge with the given controls.
    task automatic model_step(input bit r, input bit ld, input bit wr, input bit in_, input bit de,
                              input int busv, input int aluv);
        int  nv;
        bit  upd;
        nv  = m_a;
        upd = 0;
        if (r) begin
            m_a = 0; m_z = 0; m_s = 0; m_p = 0;
            return;
        end
        if (ld)       nv = busv % 256;
        else if (wr)  begin nv = aluv % 256;      upd = 1; end
        else if (in_) begin nv = (m_a + 1) % 256;   upd = 1; end
        else if (de)  begin nv = (m_a + 255) % 256; upd = 1; end
        m_a = nv;
        if (upd) begin
            m_z = (nv == 0);
            m_s = (nv >= 128);
            m_p = ($countones(nv) % 2 == 0);
        end
    endtask

    function automatic exp_t snap(input string tag);
        exp_t e;
        e.a   = m_a;
        e.z   = m_z;
        e.s   = m_s;
        e.p   = m_p;
        e.ct  = cond_of(int'(cond_sel), m_z, m_s, m_p);
        e.bo  = en ? m_a : 0;
        e.tag = tag;
        return e;
    endfunction

    // One transaction: set the inputs while clk is low, then predict the edge.
    task automatic drive(input string tag, input bit r, input bit ld, input bit wr, input bit in_,
                         input bit de, input bit e, input int cs, input int busv, input int aluv);
        @(negedge clk);
        rst = r; load = ld; wr_alu = wr; inc = in_; dec = de; en = e;
        cond_sel = CSW'(cs); bus = 16'(busv); alu_out = 8'(aluv);
        model_step(r, ld, wr, in_, de, busv, aluv);
        q.push_back(snap(tag));
    endtask

    // Monitor: compare against the queued prediction after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                check("queue_underflow", 1, 0);
            end else begin
                e = q.pop_front();
                txn++;
                check({e.tag, ".a"},         int'(a),         e.a);
                check({e.tag, ".flag_z"},    int'(flag_z),    int'(e.z));
                check({e.tag, ".flag_s"},    int'(flag_s),    int'(e.s));
                check({e.tag, ".cond_true"}, int'(cond_true), int'(e.ct));
                check({e.tag, ".bus_out"},   int'(bus_out),   e.bo);
`ifdef FLAG_PARITY_EN
                check({e.tag, ".flag_p"},    int'(flag_p),    int'(e.p));
`endif
                $display("txn %0d %s a=%02h z=%0d s=%0d ct=%0d bus_out=%04h",
                         txn, e.tag, a, flag_z, flag_s, cond_true, bus_out);
            end
        end
    end

    // Driver.
    initial begin
        rst = 1; load = 0; wr_alu = 0; inc = 0; dec = 0; en = 0;
        cond_sel = '0; bus = 16'h0; alu_out = 8'h0;
        model_step(1, 0, 0, 0, 0, 0, 0);
        q.push_back(snap("reset0"));
        drive("reset1", 1, 0, 0, 0, 0, 0, 1, 0, 0);

        // Asynchronous reset asserted mid-cycle with a pending load.
        drive("load5A", 0, 1, 0, 0, 0, 0, 1, 16'h125A, 0);
        @(negedge clk);
        load = 1; bus = 16'h1077; en = 1; cond_sel = CSW'(1);
        #2 rst = 1;
        #1;
        check("async_rst.a",         int'(a),         0);
        check("async_rst.flag_z",    int'(flag_z),    0);
        check("async_rst.flag_s",    int'(flag_s),    0);
        check("async_rst.cond_true", int'(cond_true), 1);
        model_step(1, 0, 0, 0, 0, 0, 0);
        q.push_back(snap("async_rst_edge"));

        // Load, then drive the bus.
        drive("load_C3",   0, 1, 0, 0, 0, 0, 1, 16'h12C3, 0);
        drive("en_on",     0, 0, 0, 0, 0, 1, 1, 0, 0);
        drive("en_off",    0, 0, 0, 0, 0, 0, 1, 0, 0);
        // en with load: A captures bus data, and bus_out shows A after the edge.
        drive("en_load",   0, 1, 0, 0, 0, 1, 3, 16'h0031, 0);
        // ALU writeback.
        drive("wr_00",     0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
        drive("wr_80",     0, 0, 1, 0, 0, 0, 2, 0, 8'h80);
        // Wrap in both directions.
        drive("load_FF",   0, 1, 0, 0, 0, 0, 0, 16'h00FF, 0);
        drive("inc_wrap",  0, 0, 0, 1, 0, 0, 0, 0, 0);
        drive("dec_wrap",  0, 0, 0, 0, 1, 0, 2, 0, 0);
        // Priority: load beats wr_alu and inc; Z stays 0.
        drive("priority",  0, 1, 1, 1, 0, 0, 0, 16'hAB07, 8'h00);
        drive("wr_over_inc", 0, 0, 1, 1, 1, 0, 1, 0, 8'h00);
        drive("inc_over_dec", 0, 0, 0, 1, 1, 0, 3, 0, 0);
`ifdef FLAG_PARITY_EN
        drive("par_wr03",  0, 0, 1, 0, 0, 0, 4, 0, 8'h03);
        drive("par_inc",   0, 0, 0, 1, 0, 0, 5, 0, 0);
        drive("par_sel6",  0, 0, 0, 0, 0, 0, 6, 0, 0);
        drive("par_load",  0, 1, 0, 0, 0, 0, 4, 16'h0001, 0);
`endif

        // Randomised phase.
        for (int i = 0; i < 600; i++) begin
            drive("rand",
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0),
                  $urandom_range(0, 1),
                  $urandom_range(0, (1 << CSW) - 1),
                  int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 255)));
        end

        @(posedge clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so that the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
